// File: rtl/par_serializer.sv
// Parallel-to-serial shifter with a simultaneous serial-to-parallel receive path.
// A new word may be loaded on the final-bit strobe so consecutive words stream with no gap.
module par_serializer #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int IDLE_LEVEL = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] par_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic             qout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             done_q, done_d;

  logic             last_shift;
  logic             load_acc;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    last_shift = (state_q == SHIFT) && shift_en && (cnt_q == LAST_CNT);
    load_ready = (state_q == IDLE) || last_shift;
    load_acc   = load_valid && load_ready;

    // Bits move toward the output end; ser_in fills the vacated end.
    if (MSB_FIRST != 0) begin
      shifted = {shreg_q[WIDTH-2:0], ser_in};
    end else begin
      shifted = {ser_in, shreg_q[WIDTH-1:1]};
    end

    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    done_d  = 1'b0;

    if ((state_q == SHIFT) && shift_en) begin
      shreg_d = shifted;
      if (cnt_q == LAST_CNT) begin
        done_d  = 1'b1;
        rx_d    = shifted;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // A load on the final-bit strobe overrides the return to IDLE.
    if (load_acc) begin
      shreg_d = par_in;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      rx_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    if (state_q == SHIFT) begin
      qout = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    end else begin
      qout = 1'(IDLE_LEVEL);
    end
    busy    = (state_q == SHIFT);
    done    = done_q;
    rx_data = rx_q;
  end

endmodule

// File: tb/tb_par_serializer.sv
// Drives an MSB-first (idle high) and an LSB-first (idle low) instance with identical stimulus
// and checks both against a word-level model of the serial bit order.
module tb_par_serializer;

  logic       clk;
  logic       clr;
  logic [7:0] par_in;
  logic       load_valid;
  logic       shift_en;
  logic       ser_in;

  logic       lr_m, q_m, busy_m, done_m;
  logic [7:0] rx_m;
  logic       lr_l, q_l, busy_l, done_l;
  logic [7:0] rx_l;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_rx_m;
  logic [7:0] exp_rx_l;

  par_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1)) dut_m (
    .clk(clk), .clr(clr), .par_in(par_in), .load_valid(load_valid), .load_ready(lr_m),
    .shift_en(shift_en), .ser_in(ser_in), .qout(q_m), .busy(busy_m), .done(done_m),
    .rx_data(rx_m)
  );

  par_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(0)) dut_l (
    .clk(clk), .clr(clr), .par_in(par_in), .load_valid(load_valid), .load_ready(lr_l),
    .shift_en(shift_en), .ser_in(ser_in), .qout(q_l), .busy(busy_l), .done(done_l),
    .rx_data(rx_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Received word when the first serial bit lands in the MSB.
  function automatic logic [7:0] rx_msb_model(input logic [7:0] ser);
    int v;
    v = 0;
    for (int i = 0; i < 8; i++) v = v + (int'(ser[i]) * (1 << (7 - i)));
    return 8'(v);
  endfunction

  // Received word when the first serial bit lands in the LSB.
  function automatic logic [7:0] rx_lsb_model(input logic [7:0] ser);
    int v;
    v = 0;
    for (int i = 0; i < 8; i++) v = v + (int'(ser[i]) * (1 << i));
    return 8'(v);
  endfunction

  task automatic load_word(input logic [7:0] word);
    par_in     = word;
    load_valid = 1'b1;
    shift_en   = 1'($urandom);
    ser_in     = 1'($urandom);
    #1;
    tests++;
    if ({lr_m, lr_l, busy_m, busy_l} !== 4'b1100) begin
      fails++;
      $display("FAIL load_accept: got lr/busy=%b, need 1100", {lr_m, lr_l, busy_m, busy_l});
    end
    tick();
    load_valid = 1'b0;
    shift_en   = 1'b0;
  endtask

  // Serializes one already-loaded word; ser[i] is the i-th bit driven on ser_in.
  task automatic shift_word(input logic [7:0] word, input logic [7:0] ser, input int gap,
                            input bit junk, input bit chain, input logic [7:0] next_word,
                            input bit after_chain);
    bit pend;
    bit last;
    pend = after_chain;
    for (int i = 0; i < 8; i++) begin
      for (int g = 1; g < gap; g++) begin
        shift_en   = 1'b0;
        load_valid = junk;
        par_in     = 8'($urandom);
        ser_in     = 1'($urandom);
        #1;
        tests++;
        if ({busy_m, busy_l, done_m, done_l, q_m, q_l, lr_m, lr_l} !==
            {2'b11, pend, pend, word[7-i], word[i], 2'b00}) begin
          fails++;
          $display("FAIL gap_bit%0d: got b/d/q/lr=%b, need %b", i,
                   {busy_m, busy_l, done_m, done_l, q_m, q_l, lr_m, lr_l},
                   {2'b11, pend, pend, word[7-i], word[i], 2'b00});
        end
        tick();
        pend = 1'b0;
      end
      last       = (i == 7);
      shift_en   = 1'b1;
      ser_in     = ser[i];
      load_valid = last ? chain : junk;
      par_in     = (last && chain) ? next_word : 8'($urandom);
      #1;
      tests++;
      if ({busy_m, busy_l, done_m, done_l, q_m, q_l, lr_m, lr_l} !==
          {2'b11, pend, pend, word[7-i], word[i], last, last}) begin
        fails++;
        $display("FAIL strobe_bit%0d: got b/d/q/lr=%b, need %b", i,
                 {busy_m, busy_l, done_m, done_l, q_m, q_l, lr_m, lr_l},
                 {2'b11, pend, pend, word[7-i], word[i], last, last});
      end
      tick();
      pend = 1'b0;
    end
    shift_en   = 1'b0;
    load_valid = 1'b0;
    exp_rx_m   = rx_msb_model(ser);
    exp_rx_l   = rx_lsb_model(ser);
    #1;
    tests++;
    if ({done_m, done_l, busy_m, busy_l, rx_m, rx_l} !== {2'b11, chain, chain, exp_rx_m, exp_rx_l}) begin
      fails++;
      $display("FAIL word_done: got d=%b%b b=%b%b rx=%h/%h, need d=11 b=%b%b rx=%h/%h",
               done_m, done_l, busy_m, busy_l, rx_m, rx_l, chain, chain, exp_rx_m, exp_rx_l);
    end
    $display("[TB] word %h ser %h gap %0d chain %0d -> rx_m %h rx_l %h", word, ser, gap, chain,
             rx_m, rx_l);
    if (!chain) begin
      tick();
      #1;
      tests++;
      if ({done_m, done_l, busy_m, busy_l, q_m, q_l, rx_m, rx_l} !==
          {6'b000010, exp_rx_m, exp_rx_l}) begin
        fails++;
        $display("FAIL after_done: got d/b/q=%b rx=%h/%h, need 000010 rx=%h/%h",
                 {done_m, done_l, busy_m, busy_l, q_m, q_l}, rx_m, rx_l, exp_rx_m, exp_rx_l);
      end
    end
  endtask

  task automatic test_reset;
    clr        = 1'b0;
    load_valid = 1'b1;
    par_in     = 8'hFF;
    shift_en   = 1'b1;
    ser_in     = 1'b1;
    tick();
    tick();
    #1;
    tests++;
    if ({busy_m, busy_l, done_m, done_l, q_m, q_l, lr_m, lr_l, rx_m, rx_l} !== {8'b00001011, 16'h0}) begin
      fails++;
      $display("FAIL reset: got b/d/q/lr=%b rx=%h/%h, need 00001011 rx=00/00",
               {busy_m, busy_l, done_m, done_l, q_m, q_l, lr_m, lr_l}, rx_m, rx_l);
    end
    clr        = 1'b1;
    load_valid = 1'b0;
    shift_en   = 1'b0;
    exp_rx_m   = 8'h00;
    exp_rx_l   = 8'h00;
    tick();
  endtask

  task automatic test_directed;
    load_word(8'hA5);
    shift_word(8'hA5, 8'h96, 1, 1'b0, 1'b0, 8'h00, 1'b0);
    tests++;
    if (rx_m !== 8'h69) begin
      fails++;
      $display("FAIL directed_rx_msb: got %h, need 69", rx_m);
    end
    load_word(8'hA5);
    shift_word(8'hA5, 8'hFF, 1, 1'b0, 1'b0, 8'h00, 1'b0);
    tests++;
    if (rx_l !== 8'hFF) begin
      fails++;
      $display("FAIL directed_rx_lsb: got %h, need FF", rx_l);
    end
  endtask

  task automatic test_idle_strobe;
    for (int i = 0; i < 6; i++) begin
      shift_en   = 1'b1;
      ser_in     = 1'($urandom);
      load_valid = 1'b0;
      par_in     = 8'($urandom);
      #1;
      tests++;
      if ({busy_m, busy_l, done_m, done_l, q_m, q_l, lr_m, lr_l, rx_m, rx_l} !==
          {8'b00001011, exp_rx_m, exp_rx_l}) begin
        fails++;
        $display("FAIL idle_strobe%0d: got b/d/q/lr=%b rx=%h/%h, need 00001011 rx=%h/%h", i,
                 {busy_m, busy_l, done_m, done_l, q_m, q_l, lr_m, lr_l}, rx_m, rx_l,
                 exp_rx_m, exp_rx_l);
      end
      tick();
    end
    shift_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] s1, s2;
    s1 = 8'($urandom);
    s2 = 8'($urandom);
    load_word(8'h3C);
    shift_word(8'h3C, s1, 1, 1'b0, 1'b1, 8'hC3, 1'b0);
    shift_word(8'hC3, s2, 1, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_gapped;
    logic [7:0] w, s;
    w = 8'($urandom);
    s = 8'($urandom);
    test_idle_strobe();
    load_word(w);
    shift_word(w, s, 3, 1'b1, 1'b0, 8'h00, 1'b0);
    test_idle_strobe();
  endtask

  task automatic test_abort;
    logic [7:0] w, s;
    test_reset();
    w = 8'h5A;
    load_word(w);
    for (int i = 0; i < 4; i++) begin
      shift_en = 1'b1;
      ser_in   = 1'($urandom);
      tick();
    end
    clr      = 1'b0;
    shift_en = 1'b1;
    tick();
    clr      = 1'b1;
    shift_en = 1'b0;
    exp_rx_m = 8'h00;
    exp_rx_l = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({busy_m, busy_l, done_m, done_l, q_m, q_l, rx_m, rx_l} !== {6'b000010, 16'h0}) begin
        fails++;
        $display("FAIL abort%0d: got b/d/q=%b rx=%h/%h, need 000010 rx=00/00", i,
                 {busy_m, busy_l, done_m, done_l, q_m, q_l}, rx_m, rx_l);
      end
      shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
    end
    w = 8'($urandom);
    s = 8'($urandom);
    load_word(w);
    shift_word(w, s, 1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_random;
    logic [7:0] w, nxt, s;
    bit prev_chain, chain, junk;
    int gap;
    prev_chain = 1'b0;
    w = 8'($urandom);
    for (int n = 0; n < 20; n++) begin
      nxt   = 8'($urandom);
      s     = 8'($urandom);
      gap   = int'($urandom_range(1, 3));
      junk  = 1'($urandom);
      chain = (n == 19) ? 1'b0 : 1'($urandom);
      if (!prev_chain) load_word(w);
      shift_word(w, s, gap, junk, chain, nxt, prev_chain);
      w = nxt;
      prev_chain = chain;
    end
  endtask

  initial begin
    clr        = 1'b0;
    par_in     = 8'h00;
    load_valid = 1'b0;
    shift_en   = 1'b0;
    ser_in     = 1'b0;
    exp_rx_m   = 8'h00;
    exp_rx_l   = 8'h00;
    @(negedge clk);
    test_reset();
    test_directed();
    test_idle_strobe();
    test_back_to_back();
    test_gapped();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/par_serializer.md
PAR_SERIALIZER -- requirements
Module: par_serializer

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = shift out bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 Parameter IDLE_LEVEL, default 1, qout level while no word is shifting.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 clr  input  1  one clock; reset is synchronous and active-low.
REQ-006 par_in  input  WIDTH  parallel word to serialize, sampled on load acceptance.
REQ-007 load_valid  input  1  request to load par_in.
REQ-008 load_ready  output  1  block can accept a word this cycle.
REQ-009 shift_en  input  1  bit-time strobe; one bit advances per asserted cycle.
REQ-010 ser_in  input  1  serial input, captured on each shift.
REQ-011 qout  output  1  serial output bit.
REQ-012 busy  output  1  word in progress.
REQ-013 done  output  1  one-cycle pulse, last bit of a word shifted.
REQ-014 rx_data  output  WIDTH  word assembled from ser_in, valid when done pulses.

Function
REQ-015 States: IDLE, SHIFT; busy = 1 exactly in SHIFT.
REQ-016 load_ready = 1 in IDLE; in SHIFT = 1 only in the cycle shift_en is asserted with bit count = WIDTH-1 (final bit).
REQ-017 Load accepted when load_valid && load_ready: shreg <= par_in, bit count <= 0, state <= SHIFT.
REQ-018 In SHIFT, qout = shreg[WIDTH-1] if MSB_FIRST else shreg[0]; first bit visible the cycle after acceptance, without a shift_en.
REQ-019 In IDLE, qout = IDLE_LEVEL.
REQ-020 Each shift_en cycle in SHIFT: shreg shifts one place toward the output end; ser_in enters the vacated end (bit 0 if MSB_FIRST, bit WIDTH-1 otherwise); bit count increments.
REQ-021 On the shift_en cycle with count = WIDTH-1: done <= 1 for one cycle; rx_data <= the shifted shreg value including that cycle's ser_in; state <= IDLE unless a load is accepted that same cycle.
REQ-022 Final shift plus accepted load in the same cycle: done and rx_data update as REQ-021; shreg <= new par_in; count <= 0; state stays SHIFT; zero idle cycles between words.
REQ-023 shift_en in IDLE: no effect on any state or output.
REQ-024 load_valid in SHIFT when load_ready = 0: ignored, no queuing; par_in is not sampled.
REQ-025 shift_en is a level: held high for N cycles advances N bits.
REQ-026 Bit counter width = $clog2(WIDTH); no wrap beyond WIDTH-1.
REQ-027 rx_data holds its value between done pulses.

Reset
REQ-028 With clr = 0 at a rising edge: state <= IDLE, shreg <= 0, count <= 0, rx_data <= 0, done <= 0.
REQ-029 Outputs during and after reset: qout = IDLE_LEVEL, busy = 0, load_ready = 1, done = 0.
REQ-030 Reset mid-word aborts it: no done pulse, rx_data not updated, partial word discarded.
REQ-031 clr is sampled only on clk; deassertion mid-cycle has no effect until the next edge.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1: load 0xA5, then 8 shift_en with ser_in = 0,1,1,0,1,0,0,1 -> qout sequence 1,0,1,0,0,1,0,1; done pulses once; rx_data = 0x69; busy returns to 0.
REQ-033 MSB_FIRST=0: load 0xA5 -> qout sequence 1,0,1,0,0,1,0,1 (LSB first); ser_in constant 1 -> rx_data = 0xFF.
REQ-034 Back-to-back: load_valid held with 0x3C then 0xC3 on the final-bit cycle -> 16 contiguous bits 00111100 11000011; two done pulses 8 shift_en apart; busy never drops.
REQ-035 Gapped shift_en (one strobe every 3 cycles), plus shift_en in IDLE and load_valid mid-word -> bit order unchanged; IDLE strobes and mid-word loads have no effect.
REQ-036 clr = 0 after 4 of 8 bits -> next cycle: busy = 0, qout = IDLE_LEVEL, no done, rx_data unchanged at 0; a fresh load then serializes correctly.
